f_fetch_queue: RTL and testbench

Receiving end of the fetch-request handshake driven by the next-PC generator, a DEPTH-entry FIFO between PC generation and the I-cache request stage. It accepts fetch packets (pc, mask, predict_info), tags each with a wrapping fetch id, and presents them in order to the downstream consumer. It absorbs downstream stalls so the PC generator can run ahead. On a global flush it drops all wrong-path packets.

---
 rtl/f_fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_f_fetch_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_queue.sv
// ---------------------------------------------------------------------------
// f_fetch_queue
//
// Decoupling FIFO between the next-PC generator and the I-cache request
// stage. Each accepted fetch packet (pc, mask, predict_info) is tagged with a
// wrapping fetch id and presented in order downstream. A global flush drops
// every buffered (wrong-path) packet and restarts the fetch-id sequence.
//
// Contents of this file:
//   f_fetch_queue_pkg : predict_info_t, the branch-prediction sideband.
//   handshake_if      : valid/ready packet interface with receiver/sender
//                       modports (fid is only meaningful on the sender side).
//   f_fetch_queue     : the queue itself.
//
// f_fetch_queue ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   g_flush      in   global flush, clears the queue at the clock edge
//   receiver     if   inbound packets from the next-PC generator
//   sender       if   outbound packets (plus fid) to the I-cache stage
//   occupancy_o  out  number of valid entries, $clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------

package f_fetch_queue_pkg;

  typedef struct packed {
    logic       taken;
    logic [1:0] br_slot;
    logic [7:0] ghist;
  } predict_info_t;

endpackage

interface handshake_if #(
  parameter int ID_W = 4
);
  import f_fetch_queue_pkg::*;

  logic               valid;
  logic               ready;
  logic [31:0]        pc;
  logic [1:0]         mask;
  predict_info_t      predict_info;
  logic [ID_W-1:0]    fid;

  modport receiver (
    input  valid,
    input  pc,
    input  mask,
    input  predict_info,
    output ready
  );

  modport sender (
    output valid,
    output pc,
    output mask,
    output predict_info,
    output fid,
    input  ready
  );
endinterface

module f_fetch_queue
  import f_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     g_flush,
  handshake_if.receiver            receiver,
  handshake_if.sender              sender,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Control state (reset)
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ID_W-1:0]  next_fid;

  // Payload storage (never reset; only control qualifies it)
  logic [31:0]      pc_mem   [DEPTH];
  logic [1:0]       mask_mem [DEPTH];
  predict_info_t    pi_mem   [DEPTH];
  logic [ID_W-1:0]  fid_mem  [DEPTH];

  logic             full;
  logic             vld_p0;
  logic             push;
  logic             pop;

  // Ready is a pure function of occupancy: no pass-through when full, so a
  // simultaneous push/pop at full only pops.
  assign full          = (count == CNT_W'(DEPTH));
  assign receiver.ready = !full;

  // Flush masks the head combinationally so the consumer never takes a
  // wrong-path packet in the flush cycle.
  assign vld_p0        = (count != '0) && !g_flush;
  assign sender.valid  = vld_p0;

  assign push = receiver.valid && !full && !g_flush;
  assign pop  = vld_p0 && sender.ready;

  assign sender.pc           = pc_mem[rd_ptr];
  assign sender.mask         = mask_mem[rd_ptr];
  assign sender.predict_info = pi_mem[rd_ptr];
  assign sender.fid          = fid_mem[rd_ptr];

  assign occupancy_o = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      next_fid <= '0;
    end else if (g_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      next_fid <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        next_fid <= next_fid + ID_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= receiver.pc;
      mask_mem[wr_ptr] <= receiver.mask;
      pi_mem[wr_ptr]   <= receiver.predict_info;
      fid_mem[wr_ptr]  <= next_fid;
    end
  end

  // Simulation-only protocol checks
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(receiver.valid && receiver.ready && !g_flush && full));

  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(sender.valid && sender.ready && !g_flush && (count == '0)));

  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (sender.valid && !sender.ready && !g_flush) |=>
      $stable({sender.pc, sender.mask, sender.predict_info, sender.fid}));

endmodule

// File: tb/tb_f_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_f_fetch_queue
//
// Directed bench for f_fetch_queue (DEPTH=4, ID_W=4). Inputs change 1 time
// unit after the rising edge; outputs are checked in the same window, away
// from the active edge.
// ---------------------------------------------------------------------------
module tb_f_fetch_queue;
  import f_fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int ID_W  = 4;
  localparam int PI_W  = $bits(predict_info_t);

  logic       clk;
  logic       rst_n;
  logic       g_flush;
  logic [2:0] occ;

  int total;
  int bad;

  handshake_if #(.ID_W(ID_W)) rx ();
  handshake_if #(.ID_W(ID_W)) tx ();

  f_fetch_queue #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .g_flush     (g_flush),
    .receiver    (rx.receiver),
    .sender      (tx.sender),
    .occupancy_o (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] m,
                       input predict_info_t pi);
    rx.valid        = v;
    rx.pc           = pc;
    rx.mask         = m;
    rx.predict_info = pi;
  endtask

  function automatic predict_info_t pi_pat(input int i);
    logic [PI_W-1:0] b;
    b = PI_W'(i * 37) ^ 11'h5A5;
    return predict_info_t'(b);
  endfunction

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    g_flush = 1'b0;
    tx.ready = 1'b0;
    rx.fid   = '0;
    drive(1'b0, 32'h0, 2'b00, predict_info_t'('0));

    // ---- reset state ----
    #2;
    chk("rst_occ",   64'(occ), 64'd0);
    chk("rst_ready", 64'(rx.ready), 64'd1);
    chk("rst_valid", 64'(tx.valid), 64'd0);
    #8;
    rst_n = 1'b1;
    tick();

    // ---- single packet ----
    tx.ready = 1'b1;
    drive(1'b1, 32'h1C00_0000, 2'b11, pi_pat(100));
    tick();
    drive(1'b0, 32'h0, 2'b00, predict_info_t'('0));
    chk("single_valid", 64'(tx.valid), 64'd1);
    chk("single_pc",    64'(tx.pc), 64'h1C00_0000);
    chk("single_mask",  64'(tx.mask), 64'd3);
    chk("single_pi",    64'(tx.predict_info), 64'(pi_pat(100)));
    chk("single_fid",   64'(tx.fid), 64'd0);
    tick();
    chk("single_occ0",   64'(occ), 64'd0);
    chk("single_valid0", 64'(tx.valid), 64'd0);

    // ---- fill and stall (fids 1..4, next_fid advanced by single packet) ----
    tx.ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h1C00_0000 + 32'(8 * k), 2'b01, pi_pat(k));
      chk($sformatf("fill_ready%0d", k), 64'(rx.ready), (k < 4) ? 64'd1 : 64'd0);
      tick();
    end
    drive(1'b0, 32'h0, 2'b00, predict_info_t'('0));
    chk("fill_occ4",   64'(occ), 64'd4);
    chk("fill_ready0", 64'(rx.ready), 64'd0);
    chk("fill_head_pc",  64'(tx.pc), 64'h1C00_0000);
    chk("fill_head_fid", 64'(tx.fid), 64'd1);
    tx.ready = 1'b1;
    tick();
    chk("fill_ready_back", 64'(rx.ready), 64'd1);
    chk("fill_occ3",       64'(occ), 64'd3);
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("drain_pc%0d", k),  64'(tx.pc), 64'h1C00_0000 + 64'(8 * k));
      chk($sformatf("drain_fid%0d", k), 64'(tx.fid), 64'(k + 1));
      chk($sformatf("drain_pi%0d", k),  64'(tx.predict_info), 64'(pi_pat(k)));
      tick();
    end
    chk("drain_occ0", 64'(occ), 64'd0);

    // ---- simultaneous push/pop at full (fids 5..8) ----
    tx.ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h1C00_1000 + 32'(4 * k), 2'b10, pi_pat(50 + k));
      tick();
    end
    chk("pp_occ4", 64'(occ), 64'd4);
    drive(1'b1, 32'h1C00_DEAD, 2'b11, pi_pat(99));
    tx.ready = 1'b1;
    chk("pp_ready_full", 64'(rx.ready), 64'd0);
    tick();
    drive(1'b0, 32'h0, 2'b00, predict_info_t'('0));
    chk("pp_occ3",   64'(occ), 64'd3);
    chk("pp_ready1", 64'(rx.ready), 64'd1);
    chk("pp_head_fid", 64'(tx.fid), 64'd6);
    tick();
    tick();
    chk("pp_last_pc",  64'(tx.pc), 64'h1C00_100C);
    chk("pp_last_fid", 64'(tx.fid), 64'd8);
    tick();
    chk("pp_empty", 64'(tx.valid), 64'd0);

    // ---- flush mid-stream ----
    tx.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h1C00_0080 + 32'(4 * k), 2'b01, pi_pat(k));
      tick();
    end
    chk("fl_occ3", 64'(occ), 64'd3);
    g_flush = 1'b1;
    tx.ready = 1'b1;
    drive(1'b1, 32'h1C00_0104, 2'b11, pi_pat(7));
    #1;
    chk("fl_valid_comb", 64'(tx.valid), 64'd0);
    tick();
    g_flush = 1'b0;
    drive(1'b0, 32'h0, 2'b00, predict_info_t'('0));
    chk("fl_occ0",   64'(occ), 64'd0);
    chk("fl_ready",  64'(rx.ready), 64'd1);
    chk("fl_valid0", 64'(tx.valid), 64'd0);
    drive(1'b1, 32'h1C00_0200, 2'b10, pi_pat(3));
    tick();
    drive(1'b0, 32'h0, 2'b00, predict_info_t'('0));
    chk("fl_next_pc",  64'(tx.pc), 64'h1C00_0200);
    chk("fl_next_fid", 64'(tx.fid), 64'd0);
    tick();
    chk("fl_drained", 64'(occ), 64'd0);

    // ---- restart fid sequence, then wrap-around ----
    g_flush = 1'b1;
    tick();
    g_flush = 1'b0;
    tx.ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h1C01_0000 + 32'(4 * i), 2'(i), pi_pat(i));
      tick();
      chk($sformatf("wr_valid%0d", i), 64'(tx.valid), 64'd1);
      chk($sformatf("wr_pc%0d", i),    64'(tx.pc), 64'h1C01_0000 + 64'(4 * i));
      chk($sformatf("wr_fid%0d", i),   64'(tx.fid), 64'(i % 16));
      chk($sformatf("wr_pi%0d", i),    64'(tx.predict_info), 64'(pi_pat(i)));
      chk($sformatf("wr_occ%0d", i),   64'(occ), 64'd1);
    end
    drive(1'b0, 32'h0, 2'b00, predict_info_t'('0));
    tick();
    chk("wr_occ_end", 64'(occ), 64'd0);

    // ---- asynchronous reset mid-operation ----
    tx.ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h1C00_0400 + 32'(4 * k), 2'b01, pi_pat(k));
      tick();
    end
    drive(1'b0, 32'h0, 2'b00, predict_info_t'('0));
    chk("ar_occ2", 64'(occ), 64'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid0", 64'(tx.valid), 64'd0);
    chk("ar_occ0",   64'(occ), 64'd0);
    chk("ar_ready1", 64'(rx.ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tx.ready = 1'b1;
    drive(1'b1, 32'h1C00_0300, 2'b11, pi_pat(9));
    tick();
    drive(1'b0, 32'h0, 2'b00, predict_info_t'('0));
    chk("ar_pc",  64'(tx.pc), 64'h1C00_0300);
    chk("ar_fid", 64'(tx.fid), 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
